// File: rtl/crypto_iter_unit_if.sv
// Handshake/operand bundle between the EX stage (master) and crypto_iter_unit (slave).
interface crypto_iter_unit_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            out_err;
  logic            busy;

  modport master (
    output in_valid, op, rs1, rs2, kill, out_ready,
    input  in_ready, out_valid, out_data, out_err, busy
  );

  modport slave (
    input  in_valid, op, rs1, rs2, kill, out_ready,
    output in_ready, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/crypto_iter_unit.sv
// Crypto/bitmanip unit: iterative carry-less multiply, single-cycle SHA-256 sig/sum and xperm.
// Optional feature macro CRYPTO_ZIP_EN enables ZIP/UNZIP (legal only when XLEN=32).
module crypto_iter_unit #(
  parameter int XLEN       = 32,
  parameter int CLMUL_STEP = 4,
  parameter int OP_W       = 4
) (
  input logic               clk,
  input logic               reset_n,
  crypto_iter_unit_if.slave bus
);

  localparam int NSTEPS = XLEN / CLMUL_STEP;
  localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEPS - 1);

  localparam logic [OP_W-1:0] OP_CLMUL  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_CLMULH = OP_W'(1);
  localparam logic [OP_W-1:0] OP_CLMULR = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SIG0   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SIG1   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SUM0   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SUM1   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_XPERM4 = OP_W'(7);
  localparam logic [OP_W-1:0] OP_XPERM8 = OP_W'(8);
`ifdef CRYPTO_ZIP_EN
  localparam logic [OP_W-1:0] OP_ZIP    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_UNZIP  = OP_W'(10);
  localparam bit ZIP_LEGAL = (XLEN == 32);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     out_data_q, out_data_d;
  logic                out_err_q, out_err_d;
  logic [2*XLEN-1:0]   acc_step_s;
  logic [XLEN:0]       single_res_s;
  logic                is_clmul_s;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  // SHA results live in the low word; on RV64 they are sign-extended from bit 31.
  function automatic logic [XLEN-1:0] sha_ext(input logic [31:0] r);
    return XLEN'($signed(r));
  endfunction

  function automatic logic [XLEN-1:0] xperm4(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    int              idx;
    r = '0;
    for (int i = 0; i < XLEN / 4; i++) begin
      idx = int'(b[i*4 +: 4]);
      if (idx < XLEN / 4) r[i*4 +: 4] = a[idx*4 +: 4];
      else                r[i*4 +: 4] = 4'h0;
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] xperm8(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    int              idx;
    r = '0;
    for (int i = 0; i < XLEN / 8; i++) begin
      idx = int'(b[i*8 +: 8]);
      if (idx < XLEN / 8) r[i*8 +: 8] = a[idx*8 +: 8];
      else                r[i*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

`ifdef CRYPTO_ZIP_EN
  function automatic logic [31:0] zip32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      r[2*i]   = x[i];
      r[2*i+1] = x[16+i];
    end
    return r;
  endfunction

  function automatic logic [31:0] unzip32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i]    = x[2*i];
      r[16+i] = x[2*i+1];
    end
    return r;
  endfunction
`endif

  // Returns {err, data}; anything not decoded here is illegal.
  function automatic logic [XLEN:0] single_op(input logic [OP_W-1:0] o,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN:0] r;
    case (o)
      OP_SIG0:   r = {1'b0, sha_ext(ror32(a[31:0], 5'd7) ^ ror32(a[31:0], 5'd18) ^ (a[31:0] >> 3'd3))};
      OP_SIG1:   r = {1'b0, sha_ext(ror32(a[31:0], 5'd17) ^ ror32(a[31:0], 5'd19) ^ (a[31:0] >> 4'd10))};
      OP_SUM0:   r = {1'b0, sha_ext(ror32(a[31:0], 5'd2) ^ ror32(a[31:0], 5'd13) ^ ror32(a[31:0], 5'd22))};
      OP_SUM1:   r = {1'b0, sha_ext(ror32(a[31:0], 5'd6) ^ ror32(a[31:0], 5'd11) ^ ror32(a[31:0], 5'd25))};
      OP_XPERM4: r = {1'b0, xperm4(a, b)};
      OP_XPERM8: r = {1'b0, xperm8(a, b)};
`ifdef CRYPTO_ZIP_EN
      OP_ZIP:    r = ZIP_LEGAL ? {1'b0, XLEN'(zip32(a[31:0]))}   : {1'b1, {XLEN{1'b0}}};
      OP_UNZIP:  r = ZIP_LEGAL ? {1'b0, XLEN'(unzip32(a[31:0]))} : {1'b1, {XLEN{1'b0}}};
`endif
      default:   r = {1'b1, {XLEN{1'b0}}};
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] clmul_sel(input logic [OP_W-1:0] o,
                                                input logic [2*XLEN-1:0] acc);
    logic [XLEN-1:0] r;
    case (o)
      OP_CLMULH: r = acc[2*XLEN-1:XLEN];
      OP_CLMULR: r = acc[2*XLEN-2:XLEN-1];
      default:   r = acc[XLEN-1:0];
    endcase
    return r;
  endfunction

  assign is_clmul_s   = (bus.op == OP_CLMUL) || (bus.op == OP_CLMULH) || (bus.op == OP_CLMULR);
  assign single_res_s = single_op(bus.op, bus.rs1, bus.rs2);

  // One BUSY slice: fold CLMUL_STEP multiplier bits into the accumulator.
  always_comb begin
    acc_step_s = acc_q;
    for (int j = 0; j < CLMUL_STEP; j++) begin
      if (mplier_q[j]) acc_step_s = acc_step_s ^ (mcand_q << j);
      else             acc_step_s = acc_step_s;
    end
  end

  // Next-state logic; kill overrides every other request in the same cycle.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    if (bus.kill) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op_d = bus.op;
            if (is_clmul_s) begin
              acc_d    = '0;
              cnt_d    = '0;
              mcand_d  = {{XLEN{1'b0}}, bus.rs1};
              mplier_d = bus.rs2;
              state_d  = ST_BUSY;
            end else begin
              out_err_d  = single_res_s[XLEN];
              out_data_d = single_res_s[XLEN-1:0];
              state_d    = ST_DONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          acc_d    = acc_step_s;
          mcand_d  = mcand_q << CLMUL_STEP;
          mplier_d = mplier_q >> CLMUL_STEP;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            out_data_d = clmul_sel(op_q, acc_step_s);
            out_err_d  = 1'b0;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state_d = ST_IDLE;
          else               state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_crypto_iter_unit.sv
// Directed self-checking bench for crypto_iter_unit at XLEN=32, CLMUL_STEP=4.
module tb_crypto_iter_unit;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  crypto_iter_unit_if #(.XLEN(XLEN), .OP_W(OP_W)) bus ();

  crypto_iter_unit #(.XLEN(XLEN), .CLMUL_STEP(4), .OP_W(OP_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.rs1 = a; bus.rs2 = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic consume;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_vec++; if (bus.out_err !== 1'b0)   begin n_err++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clmul;
    vec_t tab[6];
    int   lat;
    logic all_busy;
    tab[0] = '{4'd0, 32'h80000001, 32'h00000003, 32'h80000003};
    tab[1] = '{4'd1, 32'h80000001, 32'h00000003, 32'h00000001};
    tab[2] = '{4'd2, 32'h80000001, 32'h00000003, 32'h00000003};
    tab[3] = '{4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555};
    tab[4] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555};
    tab[5] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA};
    for (int i = 0; i < 6; i++) begin
      issue(tab[i].op, tab[i].a, tab[i].b);
      lat = 1;
      all_busy = 1'b1;
      while (!bus.out_valid && lat < 40) begin
        if (!bus.busy || bus.in_ready) all_busy = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
      n_vec++; if (lat !== 9) begin n_err++; $display("FAIL clmul_latency[%0d]: got %0d want 9", i, lat); end
      n_vec++; if (all_busy !== 1'b1) begin n_err++; $display("FAIL clmul_busy[%0d]: got %b want 1", i, all_busy); end
      n_vec++; if (bus.out_data !== tab[i].exp) begin n_err++; $display("FAIL clmul_data[%0d]: got %h want %h", i, bus.out_data, tab[i].exp); end
      n_vec++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL clmul_err[%0d]: got %b want 0", i, bus.out_err); end
      consume();
    end
  endtask

  task automatic test_single;
    vec_t tab[10];
    int   lat;
    tab[0] = '{4'd3, 32'h00000001, 32'h0, 32'h02004000};
    tab[1] = '{4'd3, 32'h80000000, 32'h0, 32'h11002000};
    tab[2] = '{4'd4, 32'h00000001, 32'h0, 32'h0000A000};
    tab[3] = '{4'd5, 32'h00000001, 32'h0, 32'h40080400};
    tab[4] = '{4'd6, 32'h00000001, 32'h0, 32'h04200080};
    tab[5] = '{4'd8, 32'h44332211, 32'h00010203, 32'h11223344};
    tab[6] = '{4'd8, 32'h44332211, 32'h04FF0100, 32'h00002211};
    tab[7] = '{4'd7, 32'h76543210, 32'h01234567, 32'h01234567};
    tab[8] = '{4'd7, 32'h76543210, 32'h89ABCDEF, 32'h00000000};
    tab[9] = '{4'd7, 32'hFEDCBA98, 32'h00000080, 32'h88888808};
    for (int i = 0; i < 10; i++) begin
      issue(tab[i].op, tab[i].a, tab[i].b);
      wait_valid(lat);
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL single_latency[%0d]: got %0d want 1", i, lat); end
      n_vec++; if (bus.out_data !== tab[i].exp) begin n_err++; $display("FAIL single_data[%0d]: got %h want %h", i, bus.out_data, tab[i].exp); end
      n_vec++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL single_err[%0d]: got %b want 0", i, bus.out_err); end
      consume();
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(4'd3, 32'h00000001, 32'h0);
    wait_valid(lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL bp_latency: got %0d want 1", lat); end
    bus.op = 4'd5; bus.rs1 = 32'h00000001; bus.rs2 = 32'h0; bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (bus.out_data !== 32'h02004000) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h want 02004000", c, bus.out_data); end
      n_vec++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold_ctl[%0d]: got ready=%b valid=%b want ready=0 valid=1", c, bus.in_ready, bus.out_valid);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release: got ready=%b valid=%b want ready=1 valid=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h40080400) begin
      n_err++; $display("FAIL bp_second: got valid=%b data=%h want valid=1 data=40080400", bus.out_valid, bus.out_data);
    end
    consume();
  endtask

  task automatic test_flush;
    int   lat;
    logic seen;
    issue(4'd0, 32'h80000001, 32'h00000003);
    repeat (2) begin @(posedge clk); #1; end
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    n_vec++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_idle: got busy=%b ready=%b valid=%b want 0/1/0", bus.busy, bus.in_ready, bus.out_valid);
    end
    seen = 1'b0;
    repeat (12) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_valid: got %b want 0", seen); end
    issue(4'd0, 32'h00000005, 32'h00000003);
    wait_valid(lat);
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL flush_next_latency: got %0d want 9", lat); end
    n_vec++; if (bus.out_data !== 32'h0000000F) begin n_err++; $display("FAIL flush_next_data: got %h want 0000000f", bus.out_data); end
    consume();
    // kill together with in_valid: nothing may be accepted
    bus.op = 4'd3; bus.rs1 = 32'h1; bus.rs2 = 32'h0; bus.in_valid = 1'b1; bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.kill = 1'b0;
    n_vec++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL kill_vs_in_valid: got busy=%b valid=%b want 0/0", bus.busy, bus.out_valid);
    end
    // kill together with out_ready in DONE: result dropped, back to IDLE
    issue(4'd4, 32'h1, 32'h0);
    bus.kill = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0; bus.out_ready = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL kill_vs_out_ready: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_illegal;
    int lat;
    logic [3:0] ops [2];
    ops[0] = 4'hF;
    ops[1] = 4'hB;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 32'h12345678, 32'h9ABCDEF0);
      wait_valid(lat);
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL illegal_latency[%0d]: got %0d want 1", i, lat); end
      n_vec++; if (bus.out_err !== 1'b1) begin n_err++; $display("FAIL illegal_err[%0d]: got %b want 1", i, bus.out_err); end
      n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL illegal_data[%0d]: got %h want 0", i, bus.out_data); end
      consume();
    end
  endtask

  task automatic test_zip;
    int          lat;
    logic [31:0] exp_zip, exp_unzip;
    logic        exp_err;
`ifdef CRYPTO_ZIP_EN
    exp_zip = 32'h55555555; exp_unzip = 32'h0000FFFF; exp_err = 1'b0;
`else
    exp_zip = 32'h00000000; exp_unzip = 32'h00000000; exp_err = 1'b1;
`endif
    issue(4'd9, 32'h0000FFFF, 32'h0);
    wait_valid(lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL zip_latency: got %0d want 1", lat); end
    n_vec++; if (bus.out_err !== exp_err) begin n_err++; $display("FAIL zip_err: got %b want %b", bus.out_err, exp_err); end
    n_vec++; if (bus.out_data !== exp_zip) begin n_err++; $display("FAIL zip_data: got %h want %h", bus.out_data, exp_zip); end
    consume();
    issue(4'd10, 32'h55555555, 32'h0);
    wait_valid(lat);
    n_vec++; if (bus.out_err !== exp_err) begin n_err++; $display("FAIL unzip_err: got %b want %b", bus.out_err, exp_err); end
    n_vec++; if (bus.out_data !== exp_unzip) begin n_err++; $display("FAIL unzip_data: got %h want %h", bus.out_data, exp_unzip); end
    consume();
  endtask

  task automatic test_reset_mid_busy;
    int lat;
    issue(4'd3, 32'h00000001, 32'h0);
    wait_valid(lat);
    consume();
    issue(4'd0, 32'h80000001, 32'h00000003);
    repeat (2) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_ctl: got ready=%b busy=%b valid=%b want 1/0/0", bus.in_ready, bus.busy, bus.out_valid);
    end
    n_vec++; if (bus.out_data !== 32'h0 || bus.out_err !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_data: got data=%h err=%b want 0/0", bus.out_data, bus.out_err);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rst_release: got valid=%b ready=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = 4'd0; bus.rs1 = 32'h0; bus.rs2 = 32'h0;
    bus.kill = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_clmul();
    test_single();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_zip();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
